// File: rtl/fifo_stream_reader_if.sv
// Stream-reader bus: FIFO read port on one side, valid/ready stream and
// debug counter on the other. master = the reader, slave = its surroundings.
interface fifo_stream_reader_if #(
    parameter int FIFO_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
);
    logic                   fifo_empty;
    logic                   fifo_wr_en;
    logic [FIFO_WIDTH-1:0]  fifo_data;
    logic                   fifo_rd_en;
    logic                   m_valid;
    logic                   m_ready;
    logic [FIFO_WIDTH-1:0]  m_data;
    logic [COUNT_WIDTH-1:0] word_count;

    modport master (
        input  fifo_empty, fifo_wr_en, fifo_data, m_ready,
        output fifo_rd_en, m_valid, m_data, word_count
    );

    modport slave (
        output fifo_empty, fifo_wr_en, fifo_data, m_ready,
        input  fifo_rd_en, m_valid, m_data, word_count
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drain stage behind a sync FIFO: turns the empty/rd_en port with one cycle
// of read latency into a first-word-fall-through valid/ready stream using a
// two-entry circular buffer. Reads are credit-limited so the buffer can
// always absorb every word already requested.
module fifo_stream_reader #(
    parameter int FIFO_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstN,
    fifo_stream_reader_if.master bus
);

    logic [1:0]             occ;       // words held in the buffer (0..2)
    logic                   head;      // slot presented on m_data
    logic                   pending;   // read issued last cycle, data arrives now
    logic [FIFO_WIDTH-1:0]  buf_mem [2];
    logic [COUNT_WIDTH-1:0] cnt;

    logic       valid;
    logic       pop;
    logic       rd_en;
    logic       wr_slot;
    logic [2:0] credit;

    // Handshake, read credit and capture slot
    always_comb begin
        valid   = (occ != 2'd0);
        pop     = valid & bus.m_ready;
        // Words owned after this cycle; a read is allowed only if it still fits.
        credit  = {1'b0, occ} + {2'b00, pending} - {2'b00, pop};
        // The FIFO drops a read in a write cycle, so never issue one then.
        rd_en   = rstN & ~bus.fifo_empty & ~bus.fifo_wr_en & (credit < 3'd2);
        wr_slot = head ^ occ[0];
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = valid;
    assign bus.m_data     = buf_mem[head];
    assign bus.word_count = cnt;

    // Read-in-flight flag: set by a read, cleared once its data is captured
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) pending <= 1'b0;
        else       pending <= rd_en;
    end

    // Capture returning FIFO data into the slot behind the current tail
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
        end else if (pending) begin
            buf_mem[wr_slot] <= bus.fifo_data;
        end
    end

    // Occupancy and head pointer: capture fills, pop drains and advances
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            occ  <= 2'd0;
            head <= 1'b0;
        end else begin
            occ <= occ + {1'b0, pending} - {1'b0, pop};
            if (pop) head <= ~head;
        end
    end

    // Delivered-word counter, wraps naturally
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)    cnt <= '0;
        else if (pop) cnt <= cnt + COUNT_WIDTH'(1);
    end

endmodule
